// File: rtl/disp_pkg.sv
// Shared constants and width helpers for the scanned-display blocks.
// No ports: imported by tick_gen and disp_scan_mux.
package disp_pkg;

  localparam int DIGITS_DEF      = 4;
  localparam int REFRESH_DIV_DEF = 50000;

  // 1: digit enables are active-low (common-anode)
  localparam bit DIG_ACT_LOW_DEF = 1'b1;

  // Width of the digit index, never narrower than one bit.
  function automatic int idx_w(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  // Width of the prescaler that counts 0..div-1.
  function automatic int cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 and strobes tick on terminal count.
// Ports: clk, rst (sync, active-high) -> tick (combinational, one cycle wide).
module tick_gen
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = cnt_w(REFRESH_DIV);
  localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexed digit scanner with frame-synchronous value updates.
// Ports: clk, rst, load, value, dp_in, blank_lz -> nib, dig_en, dp, blank, frame_done.
module disp_scan_mux
  import disp_pkg::*;
#(
  parameter int DIGITS      = DIGITS_DEF,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF,
  parameter bit DIG_ACT_LOW = DIG_ACT_LOW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                blank_lz,
  output logic [3:0]          nib,
  output logic [DIGITS-1:0]   dig_en,
  output logic                dp,
  output logic                blank,
  output logic                frame_done
);

  localparam int IW = idx_w(DIGITS);
  localparam int VW = 4 * DIGITS;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ONE = DIGITS'(1);
  localparam logic [DIGITS-1:0] EN0 = DIG_ACT_LOW ? ~ONE : ONE;

  logic tick;

  tick_gen #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     pend_val_q, pend_val_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic              pend_flag_q, pend_flag_d;
  logic [VW-1:0]     disp_val_q, disp_val_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;

  logic [3:0]        nib_q, nib_d;
  logic [DIGITS-1:0] dig_en_q, dig_en_d;
  logic              dp_q, dp_d;
  logic              blank_q, blank_d;
  logic              fd_q, fd_d;

  logic              boundary;
  logic              hi_zero;
  logic [DIGITS-1:0] lz;
  logic [DIGITS-1:0] onehot;

  assign boundary = tick && (idx_q == LAST);

  // Index and pending/display update
  always_comb begin
    idx_d       = idx_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    disp_val_d  = disp_val_q;
    disp_dp_d   = disp_dp_q;
    if (tick) begin
      idx_d = boundary ? '0 : idx_q + 1'b1;
    end
    if (load && boundary) begin
      // Arriving exactly on the wrap: show it in the frame starting now.
      disp_val_d  = value;
      disp_dp_d   = dp_in;
      pend_flag_d = 1'b0;
    end else if (load) begin
      pend_val_d  = value;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end else if (boundary && pend_flag_q) begin
      disp_val_d  = pend_val_q;
      disp_dp_d   = pend_dp_q;
      pend_flag_d = 1'b0;
    end
  end

  // Outputs are computed from next-state so they land one cycle after tick.
  always_comb begin
    hi_zero = 1'b1;
    lz      = '0;
    // Scan from the top digit down; a digit is a leading zero while
    // every nibble from it upward is zero. Digit 0 always shows.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero && (disp_val_d[4*i +: 4] == 4'h0);
      lz[i]   = blank_lz && hi_zero && (i != 0);
    end
    onehot   = ONE << idx_d;
    dig_en_d = DIG_ACT_LOW ? ~onehot : onehot;
    nib_d    = disp_val_d[{idx_d, 2'b00} +: 4];
    blank_d  = lz[idx_d];
    dp_d     = disp_dp_d[idx_d] && !blank_d;
    fd_d     = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      disp_val_q  <= '0;
      disp_dp_q   <= '0;
      nib_q       <= 4'h0;
      dig_en_q    <= EN0;
      dp_q        <= 1'b0;
      blank_q     <= 1'b0;
      fd_q        <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      disp_val_q  <= disp_val_d;
      disp_dp_q   <= disp_dp_d;
      nib_q       <= nib_d;
      dig_en_q    <= dig_en_d;
      dp_q        <= dp_d;
      blank_q     <= blank_d;
      fd_q        <= fd_d;
    end
  end

  assign nib        = nib_q;
  assign dig_en     = dig_en_q;
  assign dp         = dp_q;
  assign blank      = blank_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Scoreboard bench for disp_scan_mux (DIGITS=4, REFRESH_DIV=4, active-low enables).
// No ports.
module tb_disp_scan_mux;

  localparam int DIG = 4;
  localparam int DIV = 4;
  localparam int FR  = DIG * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  nib;
  logic [3:0]  dig_en;
  logic        dp;
  logic        blank;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] nib;
    logic [3:0] dig;
    logic       dp;
    logic       blank;
    logic       fd;
  } exp_t;

  exp_t q[$];

  int k = 0;
  int nvec = 0;
  int nerr = 0;

  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_pdp = '0;
  bit          m_flag = 1'b0;

  always #5 clk = ~clk;

  disp_scan_mux #(
    .DIGITS      (DIG),
    .REFRESH_DIV (DIV),
    .DIG_ACT_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .nib        (nib),
    .dig_en     (dig_en),
    .dp         (dp),
    .blank      (blank),
    .frame_done (frame_done)
  );

  task automatic model_step();
    exp_t e;
    int   idx;
    bit   bnd;
    if (rst) begin
      k      = 0;
      m_disp = '0;
      m_pend = '0;
      m_dp   = '0;
      m_pdp  = '0;
      m_flag = 1'b0;
      e.nib   = 4'h0;
      e.dig   = 4'b1110;
      e.dp    = 1'b0;
      e.blank = 1'b0;
      e.fd    = 1'b0;
    end else begin
      bnd = ((k + 1) % FR) == 0;
      if (load && bnd) begin
        m_disp = value;
        m_dp   = dp_in;
        m_flag = 1'b0;
      end else if (load) begin
        m_pend = value;
        m_pdp  = dp_in;
        m_flag = 1'b1;
      end else if (bnd && m_flag) begin
        m_disp = m_pend;
        m_dp   = m_pdp;
        m_flag = 1'b0;
      end
      idx     = ((k + 1) / DIV) % DIG;
      e.nib   = 4'(m_disp >> (4 * idx));
      e.blank = blank_lz && (idx > 0) && ((m_disp >> (4 * idx)) == '0);
      e.dp    = m_dp[idx] && !e.blank;
      e.dig   = ~(4'b0001 << idx);
      e.fd    = bnd;
      k++;
    end
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        g = {nib, dig_en, dp, blank, frame_done};
        nvec++;
        if (g !== e) begin
          nerr++;
          $display("FAIL scan t=%0t got nib=%h dig=%b dp=%b blank=%b fd=%b want nib=%h dig=%b dp=%b blank=%b fd=%b",
                   $time, g.nib, g.dig, g.dp, g.blank, g.fd,
                   e.nib, e.dig, e.dp, e.blank, e.fd);
        end
      end
    end
  end

  task automatic wait_slot(input int m);
    for (int i = 0; i < 2 * FR; i++) begin
      if (k % FR == m) return;
      @(negedge clk);
    end
    nerr++;
    $display("FAIL wait_slot got k=%0d want slot %0d", k, m);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load  = 1'b1;
    value = v;
    dp_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    if (nib !== 4'h0) begin
      nerr++;
      $display("FAIL reset got nib=%h want 0", nib);
    end
    if (dig_en !== 4'b1110) begin
      nerr++;
      $display("FAIL reset got dig_en=%b want 1110", dig_en);
    end
    if (dp !== 1'b0) begin
      nerr++;
      $display("FAIL reset got dp=%b want 0", dp);
    end
    if (blank !== 1'b0) begin
      nerr++;
      $display("FAIL reset got blank=%b want 0", blank);
    end
    if (frame_done !== 1'b0) begin
      nerr++;
      $display("FAIL reset got fd=%b want 0", frame_done);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    do_load(16'h1A2F, 4'h0);
    repeat (40) @(negedge clk);
    wait_slot(15);
    do_load(16'h1234, 4'h0);
    wait_slot(9);
    do_load(16'hABCD, 4'h5);
    repeat (40) @(negedge clk);
    wait_slot(3);
    do_load(16'h5555, 4'h0);
    wait_slot(6);
    do_load(16'h6666, 4'h2);
    repeat (20) @(negedge clk);
    wait_slot(15);
    do_load(16'h7777, 4'h0);
    repeat (20) @(negedge clk);
    blank_lz = 1'b1;
    do_load(16'h0040, 4'h0);
    repeat (36) @(negedge clk);
    do_load(16'h0000, 4'hF);
    repeat (36) @(negedge clk);
    wait_slot(13);
    do_load(16'h9999, 4'hF);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    for (int c = 0; c < 1500; c++) begin
      load  = ($urandom_range(7) == 0);
      value = 16'($urandom) >> (4 * $urandom_range(4));
      dp_in = 4'($urandom);
      rst   = ($urandom_range(199) == 0);
      if ($urandom_range(31) == 0) blank_lz = ~blank_lz;
      @(negedge clk);
    end
    rst  = 1'b0;
    load = 1'b0;
    repeat (3) @(negedge clk);
    if (nerr != 0) begin
      $display("FAIL total miscompares=%0d want 0", nerr);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
